instruction_fetch: RTL

- Fetch stage between the program counter and decode.
- Reads the current PC, issues one 16-bit instruction read at a time to instruction memory over a valid/ready handshake, and advances the PC by 2 through the counter's write port.
- Buffers fetched instructions, tagged with their address, in a small FIFO toward decode.
- Handles taken-branch redirects: flushes the FIFO and discards any in-flight memory response.

---
 rtl/ifetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/instruction_fetch.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int PC_INCREMENT       = 2;
  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetchState_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding address-tagged instructions for decode.
// Flush has priority over push and pop; the head entry is read straight from registered storage.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetchEntry_t
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  entry_t                 pushData,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 popData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  // NOTE: non-blocking assignments so every register samples pre-edge values and updates together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      // NOTE: this buffer is tiny, so it is reset to give a defined head value out of reset;
      // a large RAM-backed buffer would normally be left unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one instruction read at a time, advances the PC and buffers results for decode.
// Optional IFETCH_ALIGN_CHECK_EN flags odd redirect targets and clears bit 0 of the target.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] pcAddress,
  output logic                  pcWrite,
  output logic [ADDR_WIDTH-1:0] nextAddress,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectAddress,
  output logic                  memReqValid,
  input  logic                  memReqReady,
  output logic [ADDR_WIDTH-1:0] memReqAddress,
  input  logic                  memRespValid,
  input  logic [DATA_WIDTH-1:0] memRespData,
  output logic                  instrValid,
  input  logic                  instrReady,
  output logic [DATA_WIDTH-1:0] instrData,
  output logic [ADDR_WIDTH-1:0] instrAddress,
  output logic                  alignError
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } ifEntry_t;

  fetchState_t           state;
  fetchState_t           stateNext;
  logic [ADDR_WIDTH-1:0] tagAddress;
  logic [ADDR_WIDTH-1:0] redirectTarget;
  logic [CNT_W-1:0]      fifoCount;
  logic [CNT_W-1:0]      inFlight;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  outstanding;
  logic                  redirectTaken;
  logic                  reqFire;
  logic                  respPush;
  ifEntry_t              pushEntry;
  ifEntry_t              headEntry;

  // Combinational outputs are held quiet while reset is asserted.
  assign redirectTaken = reset_n && redirectValid;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign alignError     = redirectTaken && redirectAddress[0];
  assign redirectTarget = {redirectAddress[ADDR_WIDTH-1:1], 1'b0};
`else
  assign alignError     = 1'b0;
  assign redirectTarget = redirectAddress;
`endif

  // Space for the in-flight response is reserved when the request is issued.
  assign outstanding   = (state != REQ);
  assign inFlight      = fifoCount + CNT_W'(outstanding);
  assign memReqValid   = reset_n && (state == REQ) && !redirectValid &&
                         (inFlight < CNT_W'(FIFO_DEPTH));
  assign memReqAddress = reset_n ? pcAddress : '0;
  assign reqFire       = memReqValid && memReqReady;
  assign respPush      = (state == WAIT) && memRespValid && !redirectValid && !fifoFull;

  // NOTE: defaults first so every path assigns each output and no latch is inferred.
  always_comb begin
    pcWrite     = 1'b0;
    nextAddress = '0;
    if (redirectTaken) begin
      pcWrite     = 1'b1;
      nextAddress = redirectTarget;
    end else if (reqFire) begin
      pcWrite     = 1'b1;
      nextAddress = pcAddress + ADDR_WIDTH'(PC_INCREMENT);
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      REQ:     if (reqFire) stateNext = WAIT;
      WAIT: begin
        if (redirectValid)     stateNext = memRespValid ? REQ : DRAIN;
        else if (memRespValid) stateNext = REQ;
      end
      DRAIN:   if (memRespValid) stateNext = REQ;
      default: stateNext = REQ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= REQ;
      tagAddress <= '0;
    end else begin
      state <= stateNext;
      if (reqFire) tagAddress <= pcAddress;
    end
  end

  assign pushEntry = '{addr: tagAddress, data: memRespData};

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (ifEntry_t)
  ) u_fetchFifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (respPush),
    .pushData (pushEntry),
    .pop      (instrValid && instrReady),
    .flush    (redirectValid),
    .popData  (headEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign instrValid   = !fifoEmpty;
  assign instrData    = headEntry.data;
  assign instrAddress = headEntry.addr;

endmodule
